// File: rtl/spi_cfg_reg_ctrl.sv
// Commits validated 16-bit SPI write frames into five 8-bit PWM configuration registers.
// Optional SPI_CFG_SYNC_UPDATE_EN: writes go to shadows, outputs reload on pwm_period_start.
module spi_cfg_reg_ctrl #(
   parameter int          MAX_ADDR = 4,
   parameter logic [7:0]  RST_VAL  = 8'h00
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        frame_valid,
   input  logic [15:0] frame_data,
   input  logic        pwm_period_start,
   output logic        frame_ready,
   output logic        frame_done,
   output logic        err_pulse,
   output logic        overrun_pulse,
   output logic [7:0]  en_reg_out_7_0,
   output logic [7:0]  en_reg_out_15_8,
   output logic [7:0]  en_reg_pwm_7_0,
   output logic [7:0]  en_reg_pwm_15_8,
   output logic [7:0]  pwm_duty_cycle
);

   localparam int         NREGS = 5;
   localparam logic [6:0] MAX_A = 7'(MAX_ADDR);

   typedef enum logic [1:0] {IDLE, CHECK, COMMIT} state_t;

   state_t      state, state_nxt;
   logic [15:0] hold_p0;
   logic [6:0]  hold_addr;
   logic        hold_wr;
   logic        addr_ok;
   logic        commit;
   logic [7:0]  act_q [NREGS];

   assign hold_addr   = hold_p0[14:8];
   assign hold_wr     = hold_p0[15];
   assign addr_ok     = (hold_addr <= MAX_A);
   assign commit      = (state == COMMIT);
   assign frame_ready = (state == IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (frame_valid) state_nxt = CHECK;
         CHECK:   state_nxt = (hold_wr && addr_ok) ? COMMIT : IDLE;
         COMMIT:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Frame hold register: only loaded in IDLE, so overrun frames never disturb it.
   always_ff @(posedge clk) begin
      if (frame_ready && frame_valid) hold_p0 <= frame_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_done    <= 1'b0;
         err_pulse     <= 1'b0;
         overrun_pulse <= 1'b0;
      end else begin
         frame_done    <= commit;
         err_pulse     <= (state == CHECK) && hold_wr && !addr_ok;
         overrun_pulse <= frame_valid && !frame_ready;
      end
   end

`ifdef SPI_CFG_SYNC_UPDATE_EN
   logic [7:0] shadow_q [NREGS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) shadow_q[i] <= RST_VAL;
      end else if (commit) begin
         for (int i = 0; i < NREGS; i++)
            if (hold_addr == 7'(i)) shadow_q[i] <= hold_p0[7:0];
      end
   end

   // Outputs take the pre-write shadow when a commit lands on the same boundary edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) act_q[i] <= RST_VAL;
      end else if (pwm_period_start) begin
         for (int i = 0; i < NREGS; i++) act_q[i] <= shadow_q[i];
      end
   end
`else
   logic unused_period_start;
   assign unused_period_start = pwm_period_start;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) act_q[i] <= RST_VAL;
      end else if (commit) begin
         for (int i = 0; i < NREGS; i++)
            if (hold_addr == 7'(i)) act_q[i] <= hold_p0[7:0];
      end
   end
`endif

   assign en_reg_out_7_0  = act_q[0];
   assign en_reg_out_15_8 = act_q[1];
   assign en_reg_pwm_7_0  = act_q[2];
   assign en_reg_pwm_15_8 = act_q[3];
   assign pwm_duty_cycle  = act_q[4];

endmodule

// File: tb/tb_spi_cfg_reg_ctrl.sv
// Directed self-checking bench for spi_cfg_reg_ctrl (default build and SPI_CFG_SYNC_UPDATE_EN).
module tb_spi_cfg_reg_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        frame_valid;
   logic [15:0] frame_data;
   logic        pwm_period_start;
   logic        frame_ready, frame_done, err_pulse, overrun_pulse;
   logic [7:0]  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;

   int errors = 0;
   int checks = 0;

   spi_cfg_reg_ctrl dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .frame_valid      (frame_valid),
      .frame_data       (frame_data),
      .pwm_period_start (pwm_period_start),
      .frame_ready      (frame_ready),
      .frame_done       (frame_done),
      .err_pulse        (err_pulse),
      .overrun_pulse    (overrun_pulse),
      .en_reg_out_7_0   (en_reg_out_7_0),
      .en_reg_out_15_8  (en_reg_out_15_8),
      .en_reg_pwm_7_0   (en_reg_pwm_7_0),
      .en_reg_pwm_15_8  (en_reg_pwm_15_8),
      .pwm_duty_cycle   (pwm_duty_cycle)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   // Present one frame for a single cycle; returns at the negedge after the accepting edge.
   task automatic pulse(input logic [15:0] d);
      frame_valid = 1'b1;
      frame_data  = d;
      @(negedge clk);
      frame_valid = 1'b0;
   endtask

   // In the shadowed build, register outputs need a period boundary to become visible.
   task automatic settle();
`ifdef SPI_CFG_SYNC_UPDATE_EN
      pwm_period_start = 1'b1;
      @(negedge clk);
      pwm_period_start = 1'b0;
`endif
   endtask

   task automatic chk_regs(input string tag, input logic [7:0] r0, input logic [7:0] r1,
                           input logic [7:0] r2, input logic [7:0] r3, input logic [7:0] r4);
      chk({tag, ".r0"}, {8'h00, en_reg_out_7_0},  {8'h00, r0});
      chk({tag, ".r1"}, {8'h00, en_reg_out_15_8}, {8'h00, r1});
      chk({tag, ".r2"}, {8'h00, en_reg_pwm_7_0},  {8'h00, r2});
      chk({tag, ".r3"}, {8'h00, en_reg_pwm_15_8}, {8'h00, r3});
      chk({tag, ".r4"}, {8'h00, pwm_duty_cycle},  {8'h00, r4});
   endtask

   initial begin
      rst_n = 1'b0;
      frame_valid = 1'b0;
      frame_data = 16'h0000;
      pwm_period_start = 1'b0;
      #1;
      chk("rst.ready", {15'd0, frame_ready}, 16'd1);
      chk("rst.done", {15'd0, frame_done}, 16'd0);
      chk("rst.err", {15'd0, err_pulse}, 16'd0);
      chk("rst.ovr", {15'd0, overrun_pulse}, 16'd0);
      chk_regs("rst", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      cyc();
      cyc();
      rst_n = 1'b1;

      // Test 1: basic write to address 0
      pulse(16'h80A5);
      chk("t1.busy", {15'd0, frame_ready}, 16'd0);
      cyc();
      chk("t1.done_early", {15'd0, frame_done}, 16'd0);
      cyc();
      chk("t1.done", {15'd0, frame_done}, 16'd1);
      chk("t1.ready", {15'd0, frame_ready}, 16'd1);
      settle();
      chk_regs("t1", 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00);
      cyc();
      chk("t1.done_clr", {15'd0, frame_done}, 16'd0);

      // Test 2: top valid address and retention
      pulse(16'h8480);
      cyc();
      cyc();
      chk("t2a.done", {15'd0, frame_done}, 16'd1);
      settle();
      pulse(16'h83FF);
      cyc();
      cyc();
      chk("t2b.done", {15'd0, frame_done}, 16'd1);
      settle();
      chk_regs("t2", 8'hA5, 8'h00, 8'h00, 8'hFF, 8'h80);

      // Test 3: out-of-range, aliasing address, and read frames
      pulse(16'h85FF);
      cyc();
      chk("t3a.err", {15'd0, err_pulse}, 16'd1);
      chk("t3a.ready", {15'd0, frame_ready}, 16'd1);
      cyc();
      chk("t3a.err_clr", {15'd0, err_pulse}, 16'd0);
      chk("t3a.done", {15'd0, frame_done}, 16'd0);
      pulse(16'hC4AB);
      cyc();
      chk("t3b.err", {15'd0, err_pulse}, 16'd1);
      cyc();
      chk("t3b.done", {15'd0, frame_done}, 16'd0);
      pulse(16'h0012);
      cyc();
      chk("t3c.err", {15'd0, err_pulse}, 16'd0);
      cyc();
      chk("t3c.done", {15'd0, frame_done}, 16'd0);
      settle();
      chk_regs("t3", 8'hA5, 8'h00, 8'h00, 8'hFF, 8'h80);

      // Test 4: overrun while busy keeps the held frame
      pulse(16'h8111);
      frame_valid = 1'b1;
      frame_data  = 16'h8122;
      cyc();
      frame_valid = 1'b0;
      chk("t4.ovr", {15'd0, overrun_pulse}, 16'd1);
      cyc();
      chk("t4.ovr_clr", {15'd0, overrun_pulse}, 16'd0);
      chk("t4.done", {15'd0, frame_done}, 16'd1);
      settle();
      chk_regs("t4", 8'hA5, 8'h11, 8'h00, 8'hFF, 8'h80);

      // Test 5: reset during COMMIT
      pulse(16'h8277);
      cyc();
      cyc();
      settle();
      chk("t5.pre", {8'h00, en_reg_pwm_7_0}, 16'h0077);
      pulse(16'h8233);
      cyc();
      rst_n = 1'b0;
      #1;
      chk("t5.ready_rst", {15'd0, frame_ready}, 16'd1);
      chk_regs("t5rst", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      cyc();
      chk("t5.done", {15'd0, frame_done}, 16'd0);
      rst_n = 1'b1;
      cyc();
      chk("t5.done_after", {15'd0, frame_done}, 16'd0);
      chk("t5.ready", {15'd0, frame_ready}, 16'd1);
      chk("t5.r2", {8'h00, en_reg_pwm_7_0}, 16'h0000);

      // Test 6: period boundary behaviour
`ifdef SPI_CFG_SYNC_UPDATE_EN
      pulse(16'h8440);
      cyc();
      cyc();
      chk("t6.done", {15'd0, frame_done}, 16'd1);
      chk("t6.hold0", {8'h00, pwm_duty_cycle}, 16'h0000);
      cyc();
      chk("t6.hold1", {8'h00, pwm_duty_cycle}, 16'h0000);
      pwm_period_start = 1'b1;
      cyc();
      pwm_period_start = 1'b0;
      chk("t6.load", {8'h00, pwm_duty_cycle}, 16'h0040);
      pulse(16'h8455);
      cyc();
      pwm_period_start = 1'b1;
      cyc();
      pwm_period_start = 1'b0;
      chk("t6.co_done", {15'd0, frame_done}, 16'd1);
      chk("t6.co_old", {8'h00, pwm_duty_cycle}, 16'h0040);
      pwm_period_start = 1'b1;
      cyc();
      pwm_period_start = 1'b0;
      chk("t6.co_new", {8'h00, pwm_duty_cycle}, 16'h0055);
`else
      pulse(16'h8440);
      cyc();
      cyc();
      chk("t6.done", {15'd0, frame_done}, 16'd1);
      chk("t6.direct", {8'h00, pwm_duty_cycle}, 16'h0040);
      pwm_period_start = 1'b1;
      cyc();
      pwm_period_start = 1'b0;
      chk("t6.ignored", {8'h00, pwm_duty_cycle}, 16'h0040);
      pulse(16'h8455);
      cyc();
      pwm_period_start = 1'b1;
      cyc();
      pwm_period_start = 1'b0;
      chk("t6.co_done", {15'd0, frame_done}, 16'd1);
      chk("t6.co_direct", {8'h00, pwm_duty_cycle}, 16'h0055);
`endif
      chk_regs("t6", 8'h00, 8'h00, 8'h00, 8'h00, 8'h55);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
